// File: rtl/ndn_spi_master.sv
// ndn_spi_master
// ---------------------------------------------------------------------------
// This is a byte-framed SPI master for the router's MCU-facing SPI slave port.
// Bits move one per rising clk edge. There is no separate serial clock: the
// slave samples mosi on the same system clk.
//
// Frame sequence:
//   IDLE -> SETUP (cs low, SETUP_CYCLES cycles)
//        -> { LOAD (wait for a tx byte) -> SHIFT (8 cycles) } x frame_len
//        -> HOLD (cs low, HOLD_CYCLES cycles) -> IDLE with a one-cycle done.
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rst        asynchronous, active-low reset
//   start      one-cycle frame request; only accepted in IDLE
//   frame_len  number of bytes in the frame; latched with start; 0 = no frame
//   abort      drop the current frame on the next edge (no done, no partial rx)
//   tx_data    byte to transmit next
//   tx_valid   tx_data is valid
//   tx_ready   LOAD state: the byte on tx_data is taken this cycle
//   rx_data    last fully received byte
//   rx_valid   one-cycle pulse: rx_data was updated
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a frame completes normally
//   mosi       serial data out, MSB first
//   miso       serial data in, MSB first
//   cs         chip select, active-low
//   state_dbg  current FSM state (encoding of state_t)
//
// Handshake: a tx byte transfers on a rising edge where tx_valid and tx_ready
// are both high. tx_ready is combinational from the state register, and the
// producer must not make tx_valid depend on tx_ready. rx_valid is a pulse with
// no back-pressure.
// ---------------------------------------------------------------------------
module ndn_spi_master #(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic       abort,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       mosi,
  input  logic       miso,
  output logic       cs,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t      state_q;
  logic        cs_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        done_q;
  logic [7:0]  len_q;
  logic [7:0]  byte_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [3:0]  wait_cnt_q;
  logic [7:0]  tx_shift_q;
  logic [6:0]  rx_shift_q;

  logic [7:0]  byte_cnt_inc;
  logic [7:0]  rx_byte_full;

  assign byte_cnt_inc = byte_cnt_q + 8'd1;
  // The completed byte includes the bit that is being sampled on this edge.
  assign rx_byte_full = {rx_shift_q, miso};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cs_q       <= 1'b1;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= 8'd0;
      byte_cnt_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
      wait_cnt_q <= 4'd0;
      tx_shift_q <= 8'd0;
      rx_shift_q <= 7'd0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        // Drop the frame. A partial byte is never reported. rx_data keeps
        // the last completed byte.
        state_q    <= S_IDLE;
        cs_q       <= 1'b1;
        byte_cnt_q <= 8'd0;
        bit_cnt_q  <= 3'd0;
        wait_cnt_q <= 4'd0;
        tx_shift_q <= 8'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort && (frame_len != 8'd0)) begin
              len_q      <= frame_len;
              cs_q       <= 1'b0;
              byte_cnt_q <= 8'd0;
              wait_cnt_q <= 4'd0;
              state_q    <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (wait_cnt_q == 4'(SETUP_CYCLES - 1)) begin
              wait_cnt_q <= 4'd0;
              state_q    <= S_LOAD;
            end else begin
              wait_cnt_q <= wait_cnt_q + 4'd1;
            end
          end
          S_LOAD: begin
            // An underrun simply stalls here with cs held low.
            if (tx_valid) begin
              tx_shift_q <= tx_data;
              bit_cnt_q  <= 3'd0;
              state_q    <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            rx_shift_q <= rx_byte_full[6:0];
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= rx_byte_full;
              rx_valid_q <= 1'b1;
              byte_cnt_q <= byte_cnt_inc;
              if (byte_cnt_inc == len_q) begin
                wait_cnt_q <= 4'd0;
                state_q    <= S_HOLD;
              end else begin
                state_q    <= S_LOAD;
              end
            end
          end
          S_HOLD: begin
            if (wait_cnt_q == 4'(HOLD_CYCLES - 1)) begin
              wait_cnt_q <= 4'd0;
              cs_q       <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              wait_cnt_q <= wait_cnt_q + 4'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cs_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  // These outputs decode only registers, so an async reset clears them at once.
  assign tx_ready  = (state_q == S_LOAD);
  assign mosi      = (state_q == S_SHIFT) ? tx_shift_q[7] : 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign cs        = cs_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ndn_spi_master.sv
// Testbench for ndn_spi_master. The bench uses directed frames. Expected rx
// bytes go into exp_q, and a negedge monitor pops and compares them whenever
// rx_valid pulses. Inputs are driven #1 after the rising edge. Outputs are
// sampled on the falling edge.
module tb_ndn_spi_master;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [7:0]   frame_len = 8'd0;
  logic         abort = 1'b0;
  logic [7:0]   tx_data = 8'd0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         busy;
  logic         done;
  logic         mosi;
  logic         miso;
  logic         cs;
  logic [2:0]   state_dbg;

  ndn_spi_master #(.SETUP_CYCLES(1), .HOLD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .mosi(mosi), .miso(miso), .cs(cs), .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus queues ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tx_q[$];
  logic [W-1:0] reply_q[$];

  // The slave model loads its next reply byte on each tx handshake and shifts
  // it out MSB first. The loopback mode ties miso straight to mosi.
  logic       loopback = 1'b1;
  logic [7:0] slave_sr = 8'd0;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) slave_sr <= (reply_q.size() > 0) ? reply_q.pop_front() : 8'd0;
    else                      slave_sr <= {slave_sr[6:0], 1'b0};
  end
  assign miso = loopback ? mosi : slave_sr[7];

  // ---------------- tx driver ----------------
  int hs_cnt = 0;
  int gap_arm = 0;
  int gap_cnt = 0;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      hs_cnt++;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
      if (hs_cnt == 1) gap_cnt = gap_arm;
    end
    #1;
    if (tx_ready && gap_cnt > 0) begin
      tx_valid = 1'b0;
      gap_cnt--;
    end else if (tx_q.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = tx_q[0];
    end else begin
      tx_valid = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          cs_low_cnt = 0;
  int          cs_fall_cnt = 0;
  int          rx_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          stall_cnt = 0;
  int          rx_cyc_q[$];
  logic        cs_prev = 1'b1;
  logic [31:0] mosi_log = 32'd0;

  always @(negedge clk) begin
    if (!cs) begin
      cs_low_cnt++;
      mosi_log = {mosi_log[30:0], mosi};
    end
    if (cs_prev && !cs) cs_fall_cnt++;
    cs_prev = cs;
    if (rx_valid) begin
      rx_cnt++;
      rx_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid (t=%0t)", rx_data, $time);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx_ready && !tx_valid) begin
      stall_cnt++;
      check("stall_cs", {31'd0, cs}, 32'd0);
      check("stall_mosi", {31'd0, mosi}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic clear_stats();
    cs_low_cnt = 0; cs_fall_cnt = 0; rx_cnt = 0; done_cnt = 0;
    stall_cnt = 0; hs_cnt = 0; mosi_log = 32'd0;
    rx_cyc_q.delete();
  endtask

  task automatic start_frame(input logic [7:0] len);
    @(posedge clk); #1;
    frame_len = len;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) @(negedge clk);
    check("done_cnt", done_cnt, target);
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 400 && hs_cnt < target; i++) @(negedge clk);
    check("hs_wait", hs_cnt, target);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst_cs", {31'd0, cs}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("idle_rx_data", {24'd0, rx_data}, 32'd0);
    check("idle_mosi", {31'd0, mosi}, 32'd0);

    // Single byte, loopback.
    clear_stats();
    loopback = 1'b1;
    tx_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    start_frame(8'd1);
    wait_done(1);
    check("t1_done_latency", done_cyc - start_cyc, 12);
    repeat (4) @(negedge clk);
    check("t1_mosi_bits", {21'd0, mosi_log[10:0]}, {21'd0, 11'b00101001010});
    check("t1_cs_low", cs_low_cnt, 11);
    check("t1_rx_cnt", rx_cnt, 1);
    check("t1_done_once", done_cnt, 1);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // Three bytes with slave replies.
    @(negedge clk);
    clear_stats();
    loopback = 1'b0;
    tx_q = '{8'h11, 8'h22, 8'h33};
    reply_q = '{8'h3C, 8'h81, 8'hFF};
    exp_q.push_back(8'h3C); exp_q.push_back(8'h81); exp_q.push_back(8'hFF);
    start_frame(8'd3);
    wait_done(1);
    repeat (4) @(negedge clk);
    check("t2_handshakes", hs_cnt, 3);
    check("t2_rx_cnt", rx_cyc_q.size(), 3);
    if (rx_cyc_q.size() == 3) begin
      check("t2_gap0", rx_cyc_q[1] - rx_cyc_q[0], 9);
      check("t2_gap1", rx_cyc_q[2] - rx_cyc_q[1], 9);
    end
    check("t2_cs_low", cs_low_cnt, 29);
    check("t2_cs_falls", cs_fall_cnt, 1);

    // Underrun before byte 2.
    @(negedge clk);
    clear_stats();
    loopback = 1'b1;
    gap_arm = 5;
    tx_q = '{8'hC3, 8'h7E};
    exp_q.push_back(8'hC3); exp_q.push_back(8'h7E);
    start_frame(8'd2);
    wait_done(1);
    repeat (4) @(negedge clk);
    gap_arm = 0;
    check("t3_stall", stall_cnt, 5);
    check("t3_rx_cnt", rx_cyc_q.size(), 2);
    if (rx_cyc_q.size() == 2) check("t3_gap", rx_cyc_q[1] - rx_cyc_q[0], 14);
    check("t3_cs_falls", cs_fall_cnt, 1);

    // Abort during bit 4 of byte 2 of a 4-byte frame.
    @(negedge clk);
    clear_stats();
    loopback = 1'b0;
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    reply_q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_q.push_back(8'h9A);
    start_frame(8'd4);
    wait_hs(2);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("t4_cs_released", {31'd0, cs}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    tx_q.delete();
    reply_q.delete();
    check("t4_rx_cnt", rx_cnt, 1);
    check("t4_no_done", done_cnt, 0);
    check("t4_rx_kept", {24'd0, rx_data}, 32'h9A);
    repeat (2) @(negedge clk);
    clear_stats();
    loopback = 1'b1;
    tx_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    start_frame(8'd1);
    wait_done(1);
    repeat (4) @(negedge clk);
    check("t4_clean_rx", rx_cnt, 1);
    check("t4_clean_cs_low", cs_low_cnt, 11);

    // Async reset mid-SHIFT.
    clear_stats();
    tx_q = '{8'hFF, 8'h00};
    start_frame(8'd2);
    wait_hs(1);
    #2 rst = 1'b0;
    #1;
    check("t5_cs", {31'd0, cs}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rx_data", {24'd0, rx_data}, 32'd0);
    check("t5_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("t5_mosi", {31'd0, mosi}, 32'd0);
    @(negedge clk);
    tx_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_stats();
    start_frame(8'd0);
    repeat (20) @(negedge clk);
    check("t5_len0_falls", cs_fall_cnt, 0);
    check("t5_len0_done", done_cnt, 0);
    check("t5_len0_busy", {31'd0, busy}, 32'd0);

    // start while busy is ignored.
    clear_stats();
    tx_q.push_back(8'h96);
    exp_q.push_back(8'h96);
    start_frame(8'd1);
    #1 frame_len = 8'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1);
    repeat (20) @(negedge clk);
    check("t6_busy_start_done", done_cnt, 1);
    check("t6_busy_start_rx", rx_cnt, 1);
    check("t6_busy_start_cs_low", cs_low_cnt, 11);
    check("t6_busy_start_hs", hs_cnt, 1);

    // start together with abort in IDLE is ignored.
    clear_stats();
    @(posedge clk); #1;
    frame_len = 8'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_abort_start_falls", cs_fall_cnt, 0);
    check("t6_abort_start_cs_low", cs_low_cnt, 0);
    check("t6_abort_start_done", done_cnt, 0);

    // Final report.
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ndn_spi_master.md
Name: ndn_spi_master

Overview:
- Byte-framed SPI master that drives the router's MCU-facing SPI slave port (mosi/miso/cs) from the MCU/testbench side.
- It is the initiator opposite the router's MCU SPI slave. It sends interest/data frames (prefix, length, metadata, payload bytes) into the router and captures the router's reply bytes on miso.
- Bits move one per clk cycle, synchronous to the shared system clk. There is no separate serial clock, matching the router's SPI ports.

Parameters:
- SETUP_CYCLES, 1, clk cycles cs is held low before the first bit of a frame (range 1-15).
- HOLD_CYCLES, 1, clk cycles cs is held low after the last bit before release (range 1-15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle frame request; accepted only in IDLE.
- frame_len  input  8  bytes in the frame; sampled when start is accepted; 0 means no frame.
- abort  input  1  terminate the current frame immediately.
- tx_data  input  8  next byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  byte accepted this cycle (tx_valid and tx_ready means transfer).
- rx_data  output  8  last fully received byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a frame completes normally.
- mosi  output  1  serial data to slave, MSB first.
- miso  input  1  serial data from slave, MSB first.
- cs  output  1  chip select, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cs=1, mosi=0, tx_ready=0.
  - rx_data=0, rx_valid=0, busy=0, done=0.
  - Byte and bit counters cleared.
  - Reset mid-frame releases cs immediately, without waiting for a clock edge.
- States: IDLE, SETUP, LOAD, SHIFT, HOLD.
- IDLE:
  - start=1 with frame_len!=0 and abort=0: latch frame_len, cs<=0, go to SETUP.
  - start with frame_len==0: ignored, no cs activity, no done.
- SETUP: count SETUP_CYCLES cycles with cs low and mosi=0, then go to LOAD.
- LOAD:
  - tx_ready is asserted combinationally in LOAD.
  - If tx_valid=1: shift register <= tx_data, go to SHIFT.
  - If tx_valid=0: stay in LOAD (underrun stall). cs stays low, mosi=0, no bits are clocked, and the stall length is unbounded.
- SHIFT: exactly 8 cycles.
  - mosi = tx_shift[7], driven straight from the register.
  - Each rising edge shifts tx_shift left and shifts miso into the LSB of rx_shift. miso is sampled at the end of the cycle in which the matching mosi bit was driven.
  - After the 8th edge: rx_data <= completed byte, rx_valid=1 for the next cycle, byte_cnt += 1.
  - If byte_cnt now equals the latched frame_len, go to HOLD; otherwise go to LOAD.
- Throughput: minimum 9 cycles per byte (1 LOAD + 8 SHIFT).
- HOLD: count HOLD_CYCLES cycles with cs low and mosi=0. Then go to IDLE, cs<=1, done=1 for one cycle.
- Frame timing: for a 1-byte frame with tx_valid already high and default parameters, start is at edge 0 and done is high after edge 12.
- abort=1 in any non-IDLE state:
  - Next edge: IDLE, cs=1, mosi=0.
  - No done, and no rx_valid for a partial byte.
  - A byte already reported via rx_valid remains in rx_data.
- Simultaneous events:
  - abort and start in the same cycle: abort wins, start is ignored.
  - start while busy: ignored.
  - frame_len changes while busy: ignored.
  - rx_valid for the last byte and the first HOLD cycle coincide.
- Counters: byte_cnt is 8 bits and compared against the latched frame_len. frame_len=255 completes 255 bytes with no wrap.
- busy is high in SETUP, LOAD, SHIFT and HOLD. It drops in the same cycle done is asserted.

Test Plan:
- Single byte, loopback (miso tied to mosi delayed 0): frame_len=1, tx_data=0xA5 held valid, start pulse.
  - Required: mosi bits 1,0,1,0,0,1,0,1; cs low for 1+1+8+1 = 11 cycles; rx_data=0xA5 with one rx_valid; one done; busy low after.
- Three-byte frame, slave model returning 0x3C,0x81,0xFF on miso:
  - Required: three tx_ready handshakes; rx_valid pulses 9 cycles apart with the correct bytes; cs low continuously from SETUP to end of HOLD.
- Underrun: tx_valid dropped for 5 cycles before the 2nd byte of a 2-byte frame.
  - Required: stall in LOAD for 5 cycles, cs stays low, mosi=0, gap between rx_valid pulses = 14 cycles, frame completes normally.
- Abort during bit 4 of byte 2 of a 4-byte frame.
  - Required: cs=1 next cycle; no done; exactly one rx_valid seen; new start afterwards runs a clean frame.
- Async reset mid-SHIFT.
  - Required: cs=1 and busy=0 with no clk edge; all outputs at reset values; frame_len=0 start afterwards gives no cs activity and no done.
- start during busy, and start+abort in the same IDLE cycle.
  - Required: both ignored, frame count unchanged, cs stays high in the IDLE case.
